// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// Registered grant index/valid drive a downstream 2-to-4 decoder select.
module rr_arbiter_4 #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [1:0] grant_idx,
   output logic       grant_valid,
   output logic       grant_timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   state_t     state, state_n;
   logic [1:0] ptr, ptr_n;
   logic [7:0] hold_cnt, hold_cnt_n;
   logic [1:0] idx_n;
   logic       timeout_n;

   // First set bit of r scanning p, p+1, p+2, p+3 (mod 4).
   function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] r);
      logic [1:0] res;
      logic [1:0] idx;
      res = p;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) res = idx;
      end
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ptr           <= 2'd0;
         hold_cnt      <= 8'd0;
         grant_idx     <= 2'd0;
         grant_timeout <= 1'b0;
      end else begin
         state         <= state_n;
         ptr           <= ptr_n;
         hold_cnt      <= hold_cnt_n;
         grant_idx     <= idx_n;
         grant_timeout <= timeout_n;
      end
   end

   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      hold_cnt_n = hold_cnt;
      idx_n      = grant_idx;
      timeout_n  = 1'b0;
      case (state)
         IDLE: begin
            if (req != 4'd0) begin
               state_n    = GRANT;
               idx_n      = pick(ptr, req);
               hold_cnt_n = 8'd1;
            end
         end
         GRANT: begin
            if (req[grant_idx] && hold_cnt < HOLD_MAX) begin
               hold_cnt_n = 8'(hold_cnt + 8'd1);
            end else begin
               // Releasing holder drops to lowest priority for the next pick.
               ptr_n     = grant_idx + 2'd1;
               timeout_n = req[grant_idx];
               if (req != 4'd0) begin
                  idx_n      = pick(grant_idx + 2'd1, req);
                  hold_cnt_n = 8'd1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign grant_valid = (state == GRANT);

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter with bounded hold time. Produces a registered 2-bit grant index plus a valid flag that directly drive the select input of the downstream 2-to-4 decoder, which expands the index into per-requester one-hot enables. Fairness comes from a rotating priority pointer. A per-grant hold counter stops any single requester from monopolising the shared resource.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may last; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input [3:0]: request per requester; level-sensitive; bit i belongs to requester i.
- `grant_idx` output [1:0]: index of the current or last granted requester; feeds the decoder select.
- `grant_valid` output 1: high while a grant is active; the decoder output is meaningful only when high.
- `grant_timeout` output 1: one-cycle pulse marking a grant that ended by reaching `MAX_HOLD`.

## Operation
- Internal state:
  - FSM: `IDLE`, `GRANT`.
  - Priority pointer `ptr[1:0]`.
  - Hold counter `hold_cnt[7:0]`.
- Reset, applied on any edge with `rst`=1, including mid-grant:
  - FSM → `IDLE`; `ptr`=0; `hold_cnt`=0.
  - `grant_idx`=2'b00; `grant_valid`=0; `grant_timeout`=0.
- Selection function `pick(ptr, req)`: the first set bit of `req` scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- `IDLE` (`grant_valid`=0):
  - If `req`≠0 at an edge: → `GRANT`; `grant_idx`←pick(ptr, req); `hold_cnt`←1.
  - Otherwise stay in `IDLE`; `grant_idx` holds its last value.
- `GRANT` (`grant_valid`=1): at each edge, let g=`grant_idx`.
  - Continue when `req[g]`=1 and `hold_cnt`<`MAX_HOLD`: `hold_cnt`←`hold_cnt`+1; `grant_idx` unchanged.
  - Release when `req[g]`=0 or `hold_cnt`=`MAX_HOLD`:
    - `ptr`←g+1 (mod 4; 3 wraps to 0).
    - Pick a new winner using the updated `ptr` and the current `req`. If `req`≠0: stay in `GRANT`; `grant_idx`←new winner; `hold_cnt`←1 (back-to-back, no idle bubble). If `req`=0: → `IDLE`; `grant_valid`←0.
  - `grant_timeout`←1 for one cycle only when the release cause is `hold_cnt`=`MAX_HOLD` with `req[g]` still 1. It is 0 otherwise.
- A timed-out requester that is the only requester is re-granted immediately, with a fresh count and `grant_timeout` pulsing.
- Simultaneous requests are resolved only by `ptr`; the holder of the grant being released has the lowest priority in the next pick.
- Requests from non-holders never pre-empt an active grant.
- `MAX_HOLD`=1: every grant lasts exactly one cycle. With continuous requests the grant rotates every cycle, and `grant_timeout` pulses on every release where the holder still requests.

## Timing
- All outputs are registered; there are no combinational paths from `req` to any output.
- Request latency: `req` rising before edge N gives `grant_valid`=1 and a valid `grant_idx` after edge N (1 cycle).
- Release latency: holder drops `req[g]` before edge M gives the new index or `grant_valid`=0 after edge M.
- Maximum grant length: exactly `MAX_HOLD` cycles of `grant_valid`=1 with an unchanged `grant_idx`.
- `grant_timeout` is coincident with the first cycle of the following grant, or of `IDLE`.
- Starvation bound: any request held continuously is granted within 3×`MAX_HOLD`+1 cycles.

## Test plan
- Reset, then `req`=0000 for 5 cycles → `grant_valid`=0, `grant_idx`=00, `grant_timeout`=0 throughout.
- `req`=0100 asserted before edge N → after N: `grant_idx`=10, `grant_valid`=1. Drop `req` before edge N+3 → after N+3: `grant_valid`=0, `grant_idx` stays 10. Next pick starts at `ptr`=3.
- From reset, `req`=1111 held with each holder dropping after 2 cycles → grant order 00, 01, 10, 11, 00, with no idle cycles between grants.
- `MAX_HOLD`=8, `req`=0011 held constantly → index 00 for exactly 8 cycles, then 01 for 8, then 00; `grant_timeout` pulses once at each switch.
- `MAX_HOLD`=8, `req`=1000 only → index 11 for 8 cycles, `grant_timeout` pulses, index 11 re-granted with `grant_valid` never dropping. Separately, `MAX_HOLD`=1 with `req`=1111 → index changes every cycle: 00, 01, 10, 11, 00.
- `rst` asserted mid-grant (`grant_idx`=10, `hold_cnt`=5) with `req`=1111 held → after the reset edge all outputs are 0. After `rst` deasserts, the first grant is 00 (`ptr`=0).
